// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and decode helpers
//
// Purpose : shared timing constants (display, porch and sync widths), the
//           derived line/frame totals and the pixel/line counter width.
// Ports   : none (package).

package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int TICK_DIV_DEF  = 4;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Inclusive window test on an unsigned counter value.
    function automatic logic in_range(input logic [CNT_W-1:0] val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - timing bundle from the sync generator to the video pipeline
//
// Purpose : carries pixel enable, pixel coordinates, blanking and sync.
// Signals : p_tick, pixel_x[9:0], pixel_y[9:0], video_on, hsync (active-low),
//           vsync (active-low), frame_start.
// Modports: master - driven by vga_sync_gen; slave - consumed downstream.

interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic             p_tick;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             video_on;
    logic             hsync;
    logic             vsync;
    logic             frame_start;

    modport master (
        output p_tick,
        output pixel_x,
        output pixel_y,
        output video_on,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        input p_tick,
        input pixel_x,
        input pixel_y,
        input video_on,
        input hsync,
        input vsync,
        input frame_start
    );

endinterface

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - mod-TICK_DIV counter producing the one-cycle pixel enable
//
// Purpose : divides the system clock into a pixel-rate enable pulse.
// Ports   : clk      - system clock
//           rst      - asynchronous active-low reset
//           o_p_tick - high for one clk every TICK_DIV cycles

module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_p_tick
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] r_div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Decoded straight from the register so the tick is a clean function of
    // state; reset forces r_div to 0, which keeps the tick low.
    assign o_p_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator (counters, sync, blanking)
//
// Purpose : pixel/line counters advanced on the pixel tick, registered
//           active-low sync pulses, video_on and a start-of-frame pulse.
// Ports   : clk  - system clock (100 MHz)
//           rst  - asynchronous active-low reset
//           vga  - vga_sync_gen_if.master: p_tick, pixel_x, pixel_y,
//                  video_on, hsync, vsync, frame_start

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam int HS_LO = H_DISPLAY + H_FRONT;
    localparam int HS_HI = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_LO = V_DISPLAY + V_FRONT;
    localparam int VS_HI = V_DISPLAY + V_FRONT + V_SYNC - 1;

    logic             w_p_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;

    pixel_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk      (clk),
        .rst      (rst),
        .o_p_tick (w_p_tick)
    );

    // Next-state counters. The registered decodes below use these values so
    // sync/blanking land on the same edge as the counters they describe.
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        w_h_wrap = w_p_tick && (r_h == H_LAST);
        w_v_wrap = w_h_wrap && (r_v == V_LAST);
        if (w_p_tick) begin
            w_h_next = w_h_wrap ? '0 : r_h + CNT_W'(1);
        end
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= !in_range(w_h_next, HS_LO, HS_HI);
            r_vsync       <= !in_range(w_v_next, VS_LO, VS_HI);
            // video_on is 0 during reset and loads 1 on the first edge
            // afterwards because (0,0) is a visible pixel.
            r_video_on    <= in_range(w_h_next, 0, H_DISPLAY - 1) &&
                             in_range(w_v_next, 0, V_DISPLAY - 1);
            // Only the wrap out of the last pixel of the frame marks a frame
            // start; coming out of reset into (0,0) does not.
            r_frame_start <= w_v_wrap;
        end
    end

    assign vga.p_tick      = w_p_tick;
    assign vga.pixel_x     = r_h;
    assign vga.pixel_y     = r_v;
    assign vga.video_on    = r_video_on;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and reduced timing)

module tb_vga_sync_gen;

    // Default 640x480 instance
    localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_T = 4;
    // Reduced instance: 14-pixel lines, 9-line frames, 2 clk per pixel
    localparam int B_HD = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VD = 6, B_VF = 1, B_VS = 1, B_VB = 1, B_T = 2;
    localparam int B_FRAME_CLK = (B_HD + B_HF + B_HS + B_HB) * (B_VD + B_VF + B_VS + B_VB) * B_T;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_sync_gen_if if_a();
    vga_sync_gen_if if_b();

    vga_sync_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (if_a)
    );

    vga_sync_gen #(
        .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .TICK_DIV  (B_T)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (if_b)
    );

    // Clock edges seen since each reset was last released.
    longint n_a;
    longint n_b;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) n_a <= 0;
        else        n_a <= n_a + 1;
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) n_b <= 0;
        else        n_b <= n_b + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int hs_low = 0;
    longint fs_q[$];

    // Expected outputs after n edges: every TICK_DIV edges one pixel is
    // consumed, so the screen position is just the pixel count folded into
    // line and frame size. Packed as {p_tick, x, y, video_on, hsync, vsync, frame_start}.
    function automatic logic [24:0] model(input longint n,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb,
                                          input int t);
        longint ht, vt, p, x, y;
        logic pt, vo, hsy, vsy, fs;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = n / t;
        x   = p % ht;
        y   = (p / ht) % vt;
        pt  = (n % t) == (t - 1);
        vo  = (n > 0) && (x < hd) && (y < vd);
        hsy = !((x >= hd + hf) && (x < hd + hf + hs));
        vsy = !((y >= vd + vf) && (y < vd + vf + vs));
        fs  = (n > 0) && ((n % t) == 0) && ((p % (ht * vt)) == 0);
        return {pt, 10'(x), 10'(y), vo, hsy, vsy, fs};
    endfunction

    function automatic logic [24:0] exp_a(input longint n);
        return model(n, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_T);
    endfunction

    function automatic logic [24:0] exp_b(input longint n);
        return model(n, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_T);
    endfunction

    function automatic logic [24:0] obs_a();
        return {if_a.p_tick, if_a.pixel_x, if_a.pixel_y, if_a.video_on,
                if_a.hsync, if_a.vsync, if_a.frame_start};
    endfunction

    function automatic logic [24:0] obs_b();
        return {if_b.p_tick, if_b.pixel_x, if_b.pixel_y, if_b.video_on,
                if_b.hsync, if_b.vsync, if_b.frame_start};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock, then compare both instances against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        chk("dut_a_state", {7'd0, obs_a()}, {7'd0, exp_a(n_a)});
        chk("dut_b_state", {7'd0, obs_b()}, {7'd0, exp_b(n_b)});
        if (n_a > 0 && n_a <= 3200 && if_a.hsync === 1'b0) hs_low++;
        if (if_b.frame_start === 1'b1) fs_q.push_back(n_b);
    endtask

    initial begin
        int guard;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Held in reset: everything at reset values.
        repeat (3) step();
        chk("reset_video_on", {31'd0, if_a.video_on}, 32'd0);
        chk("reset_hsync",    {31'd0, if_a.hsync},    32'd1);

        // Release both on a falling edge so the next rising edge is edge 1.
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(); step();
        chk("tick_low_edge2", {31'd0, if_a.p_tick}, 32'd0);
        step();
        chk("tick_first_edge3", {31'd0, if_a.p_tick}, 32'd1);
        chk("x_before_edge4",   {22'd0, if_a.pixel_x}, 32'd0);
        step();
        chk("x_after_edge4",    {22'd0, if_a.pixel_x}, 32'd1);
        chk("tick_low_edge4",   {31'd0, if_a.p_tick},  32'd0);

        // Two full lines of the default timing and ~25 reduced frames.
        repeat (6400) step();
        chk("hsync_low_clk_line0", 32'(hs_low), 32'd384);
        chk("line1_y", {22'd0, if_a.pixel_y}, 32'd2);

        chk("frame_start_count", 32'(fs_q.size()), 32'(6404 / B_FRAME_CLK));
        foreach (fs_q[i])
            chk("frame_start_at", 32'(fs_q[i]), 32'(B_FRAME_CLK * (i + 1)));

        // Reset the default instance mid-line inside the hsync pulse.
        guard = 0;
        while (if_a.pixel_x !== 10'd700 && guard < 4000) begin
            step();
            guard++;
        end
        chk("reach_x700", 32'(guard < 4000), 32'd1);
        chk("hsync_low_x700", {31'd0, if_a.hsync}, 32'd0);
        #2 rst_a = 1'b0;
        #1;
        chk("async_reset_a", {7'd0, obs_a()}, {7'd0, exp_a(0)});
        chk("async_hsync_high", {31'd0, if_a.hsync}, 32'd1);
        repeat (2) step();
        rst_a = 1'b1;
        repeat (900) step();

        // Random-length runs with asynchronous resets of the reduced instance.
        fs_q.delete();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 600)) step();
            #($urandom_range(1, 4));
            rst_b = 1'b0;
            #1;
            chk("async_reset_b", {7'd0, obs_b()}, {7'd0, exp_b(0)});
            repeat ($urandom_range(1, 5)) step();
            rst_b = 1'b1;
        end
        repeat (600) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock: a 25 MHz pixel-enable tick, horizontal/vertical pixel counters and active-low sync pulses. Sits directly upstream of the character generator (`caracter`). It feeds that block's `video_on`, `pixel_x` and `pixel_y`, and drives `hsync`/`vsync` to the connector.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `TICK_DIV`, 4, clk cycles per pixel; must be ≥ 2

Ports:
- `clk`  in  1  system clock, 100 MHz; the single clock for the block
- `rst`  in  1  reset; asynchronous, active-low
- `p_tick`  out  1  pixel enable, high for exactly one clk cycle every `TICK_DIV` cycles
- `pixel_x`  out  10  current column, 0 to H_TOTAL-1
- `pixel_y`  out  10  current line, 0 to V_TOTAL-1
- `video_on`  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `frame_start`  out  1  one-clk pulse when the counters enter (0,0) from a wrap

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
  - Both must be ≤ 1024.
- Divider `div`:
  - Counts 0 to TICK_DIV-1 every clk and then wraps.
  - `p_tick` = (div == TICK_DIV-1), decoded from the register.
- Horizontal counter `h`:
  - Advances only on clk edges where `p_tick`=1.
  - At H_TOTAL-1 it wraps to 0 and advances the vertical counter `v`.
- Vertical counter `v`: wraps from V_TOTAL-1 to 0.
- Simultaneous wrap at (799,524): `h` and `v` both go to 0 on the same edge.
- `pixel_x`/`pixel_y` are the `h`/`v` registers. Arithmetic is unsigned 10-bit and never exceeds TOTAL-1.
- `hsync`, `vsync`, `video_on` and `frame_start` are registered. They are decoded from the next-state counter values, so they align cycle-exactly with `pixel_x`/`pixel_y`.
- `hsync` = 0 iff pixel_x ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656 to 751.
- `vsync` = 0 iff pixel_y ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490 to 491.
- `frame_start` = 1 for the single clk cycle in which the counters first show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted after reset.
- Reset (asynchronous, any time, including mid-frame):
  - Outputs immediately take: div=0, pixel_x=0, pixel_y=0, p_tick=0, hsync=1, vsync=1, video_on=0, frame_start=0.
  - On the first clk edge after `rst` rises, `video_on` loads 1, since (0,0) is visible.

## Timing
- Pixel period: TICK_DIV clk (40 ns).
- Line: H_TOTAL·TICK_DIV = 3200 clk.
- Frame: 1,680,000 clk.
- Timeline after `rst` deasserts, with clk edges numbered from 1:
  - `p_tick` is first high after edge 3.
  - `pixel_x` becomes 1 after edge 4.
  - After that, `pixel_x` increments every 4 edges.
- `pixel_x` and `pixel_y` hold steady between ticks. The downstream block may sample them on any clk, with no additional latency.
- Sync and video_on latency relative to the counters: 0 cycles (same-cycle consistent).
- All outputs are glitch-free register outputs.

## Structure
- Package `vga_timing_pkg`:
  - The default timing constants (display, porch and sync values for 640x480).
  - The derived H_TOTAL/V_TOTAL.
  - The counter width (10).
- Sub-module `pixel_tick_div`: a mod-TICK_DIV counter producing `p_tick`. Everything else stays in `vga_sync_gen`.

## Test plan
- Reset release → `p_tick` first high in cycle 4; `pixel_x` 0→1 after edge 4; then `p_tick` every 4 cycles, exactly 1 cycle wide.
- Run one full line → `hsync` low for exactly 96·4 = 384 clk while `pixel_x` = 656 to 751; `video_on` drops at `pixel_x` = 640; `pixel_y` 0→1 when `pixel_x` wraps 799→0.
- Run two frames → `vsync` low while `pixel_y` = 490 to 491 (6400 clk); `frame_start` pulses exactly once per frame, 1,680,000 clk apart, coincident with (0,0).
- Check at the (799,524)→(0,0) transition → both counters zero on the same edge; `video_on` rises on that edge; no out-of-range values ever observed.
- Assert `rst` mid-line at `pixel_x` = 700 (inside hsync) → `hsync` returns to 1 and counters go to 0 asynchronously, before the next clk edge; normal sequence restarts after release.
- Override parameters to H_DISPLAY=8, H_FRONT=2, H_SYNC=2, H_BACK=2 (V scaled similarly), TICK_DIV=2 → line = 14 pixels = 28 clk; `hsync` low at `pixel_x` 10 to 11.
